// File: rtl/freq_meter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// freq_meter_pkg : shared types and constants for the equal-precision meter
// Rev 1.0
// ----------------------------------------------------------------------------
package freq_meter_pkg;

  localparam int     CW_DEFAULT = 32;
  localparam longint F_CLK      = 64'd50_000_000;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_OPEN  = 3'd1,
    COUNT      = 3'd2,
    WAIT_CLOSE = 3'd3,
    DONE       = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sync_edge_det : 2-FF synchroniser with one-cycle rising-edge pulse
// Rev 1.0
// ----------------------------------------------------------------------------
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/equal_precision_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// equal_precision_counter : fx-synchronous gate, counts fx periods and clk cycles
// Rev 1.0
// ----------------------------------------------------------------------------
module equal_precision_counter
  import freq_meter_pkg::*;
#(
  parameter int               CW      = CW_DEFAULT,
  parameter int               TMO_W   = 24,
  parameter logic [TMO_W-1:0] TIMEOUT = 24'd10_000_000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          gate_tick,
  input  logic          fx,
  output logic [CW-1:0] nx_out,
  output logic [CW-1:0] ns_out,
  output logic          result_valid,
  output logic          busy,
  output logic          overflow,
  output logic          no_signal
);

  localparam logic [CW-1:0]    CNT_MAX  = '1;
  localparam logic [TMO_W-1:0] TMO_LAST = TIMEOUT - 1'b1;

  logic tick_rise, fx_rise;

  sync_edge_det u_sync_gate (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (gate_tick),
    .rise     (tick_rise)
  );

  sync_edge_det u_sync_fx (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (fx),
    .rise     (fx_rise)
  );

  state_e           state_q, state_d;
  logic [CW-1:0]    nx_q, nx_d, ns_q, ns_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             ovf_q, ovf_d, nosig_q, nosig_d;
  logic [CW-1:0]    nx_out_q, nx_out_d, ns_out_q, ns_out_d;
  logic             rv_q, rv_d, ovf_out_q, ovf_out_d, nosig_out_q, nosig_out_d;

  always_comb begin
    state_d     = state_q;
    nx_d        = nx_q;
    ns_d        = ns_q;
    tmo_d       = tmo_q;
    ovf_d       = ovf_q;
    nosig_d     = nosig_q;
    nx_out_d    = nx_out_q;
    ns_out_d    = ns_out_q;
    ovf_out_d   = ovf_out_q;
    nosig_out_d = nosig_out_q;
    rv_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && tick_rise) begin
          state_d = WAIT_OPEN;
          tmo_d   = '0;
        end
      end
      WAIT_OPEN: begin
        // An fx edge coinciding with the timeout still opens the gate.
        if (fx_rise) begin
          state_d = COUNT;
          nx_d    = '0;
          ns_d    = '0;
          ovf_d   = 1'b0;
          nosig_d = 1'b0;
        end else if (tmo_q == TMO_LAST) begin
          state_d = DONE;
          nx_d    = '0;
          ns_d    = '0;
          ovf_d   = 1'b0;
          nosig_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      COUNT, WAIT_CLOSE: begin
        if (ns_q == CNT_MAX) ovf_d = 1'b1;
        else                 ns_d  = ns_q + 1'b1;
        if (fx_rise) begin
          if (nx_q == CNT_MAX) ovf_d = 1'b1;
          else                 nx_d  = nx_q + 1'b1;
        end
        if (state_q == COUNT) begin
          if (tick_rise) begin
            state_d = WAIT_CLOSE;
            tmo_d   = '0;
          end
        end else if (fx_rise) begin
          state_d = DONE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = DONE;
          nosig_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      DONE: begin
        nx_out_d    = nosig_q ? '0 : nx_q;
        ns_out_d    = nosig_q ? '0 : ns_q;
        ovf_out_d   = ovf_q;
        nosig_out_d = nosig_q;
        rv_d        = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      nx_q        <= '0;
      ns_q        <= '0;
      tmo_q       <= '0;
      ovf_q       <= 1'b0;
      nosig_q     <= 1'b0;
      nx_out_q    <= '0;
      ns_out_q    <= '0;
      rv_q        <= 1'b0;
      ovf_out_q   <= 1'b0;
      nosig_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      nx_q        <= nx_d;
      ns_q        <= ns_d;
      tmo_q       <= tmo_d;
      ovf_q       <= ovf_d;
      nosig_q     <= nosig_d;
      nx_out_q    <= nx_out_d;
      ns_out_q    <= ns_out_d;
      rv_q        <= rv_d;
      ovf_out_q   <= ovf_out_d;
      nosig_out_q <= nosig_out_d;
    end
  end

  assign nx_out       = nx_out_q;
  assign ns_out       = ns_out_q;
  assign result_valid = rv_q;
  assign overflow     = ovf_out_q;
  assign no_signal    = nosig_out_q;
  assign busy         = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_equal_precision_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_equal_precision_counter : scoreboard bench, wide-counter and 8-bit DUTs
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_equal_precision_counter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en_a = 1'b0, en_b = 1'b0, gate_tick = 1'b0, fx = 1'b0;
  logic [31:0] nx_a, ns_a;
  logic [7:0]  nx_b, ns_b;
  logic rv_a, busy_a, ovf_a, nos_a;
  logic rv_b, busy_b, ovf_b, nos_b;

  equal_precision_counter #(.CW(32), .TMO_W(24), .TIMEOUT(24'd50)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .gate_tick(gate_tick), .fx(fx),
    .nx_out(nx_a), .ns_out(ns_a), .result_valid(rv_a), .busy(busy_a),
    .overflow(ovf_a), .no_signal(nos_a)
  );

  equal_precision_counter #(.CW(8), .TMO_W(24), .TIMEOUT(24'd50)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .gate_tick(gate_tick), .fx(fx),
    .nx_out(nx_b), .ns_out(ns_b), .result_valid(rv_b), .busy(busy_b),
    .overflow(ovf_b), .no_signal(nos_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint nx;
    longint ns;
    bit     ovf;
    bit     nos;
    int     t0;
    int     lmin;
    int     lmax;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   busy_seen = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic score(input string tag, input exp_t e, input logic [63:0] nx,
                       input logic [63:0] ns, input logic ovf, input logic nos);
    check({tag, "_nx"}, nx, e.nx);
    check({tag, "_ns"}, ns, e.ns);
    check({tag, "_ovf"}, 64'(ovf), 64'(e.ovf));
    check({tag, "_nosig"}, 64'(nos), 64'(e.nos));
    if (e.lmax != 0)
      check({tag, "_latency_in_window"},
            64'((cyc - e.t0 >= e.lmin) && (cyc - e.t0 <= e.lmax)), 64'd1);
  endtask

  always @(negedge clk) begin
    if (busy_a || busy_b) busy_seen = 1'b1;
    if (rv_a) begin
      if (q_a.size() == 0) check("a_unexpected_result", 64'd1, 64'd0);
      else score("a", q_a.pop_front(), 64'(nx_a), 64'(ns_a), ovf_a, nos_a);
    end
    if (rv_b) begin
      if (q_b.size() == 0) check("b_unexpected_result", 64'd1, 64'd0);
      else score("b", q_b.pop_front(), 64'(nx_b), 64'(ns_b), ovf_b, nos_b);
    end
  end

  task automatic drain();
    for (int i = 0; i < 100 && (q_a.size() + q_b.size()) != 0; i++) @(negedge clk);
    check("drain_pending", 64'(q_a.size() + q_b.size()), 64'd0);
    repeat (5) @(negedge clk);
  endtask

  // Pin-level measurement: an ignored tick at 2 (en low), en raised at 10,
  // gate ticks at 20 and 20+gate, en dropped shortly after the gate opens.
  task automatic run_meas(input int p, input int ph, input int gate, input bit use_b);
    int   t0 = 20;
    int   t1 = 20 + gate;
    int   open = -1;
    int   close = -1;
    exp_t e;
    for (int k = 0; k < 2000 && close < 0; k++) begin
      int r = ph + k * p;
      if (open < 0 && r > t0) open = r;
      if (r > t1) close = r;
    end
    e.ns = close - open;
    e.nx = (close - open) / p;
    e.ovf = 1'b0; e.nos = 1'b0; e.t0 = 0; e.lmin = 0; e.lmax = 0;
    if (use_b) begin
      e.ovf = (e.ns > 255) || (e.nx > 255);
      if (e.ns > 255) e.ns = 255;
      if (e.nx > 255) e.nx = 255;
      q_b.push_back(e);
    end else begin
      q_a.push_back(e);
    end
    for (int i = 0; i < close + 6; i++) begin
      @(negedge clk);
      fx = (i >= ph) && (((i - ph) % p) < p / 2);
      gate_tick = (i >= 2 && i < 6) || (i >= t0 && i < t0 + 4) || (i >= t1 && i < t1 + 4);
      if (i == 10) begin
        if (use_b) en_b = 1'b1;
        else       en_a = 1'b1;
      end
      if (i == open + 5) begin
        en_a = 1'b0;
        en_b = 1'b0;
      end
    end
    @(negedge clk);
    fx = 1'b0;
    gate_tick = 1'b0;
    drain();
  endtask

  initial begin
    exp_t e;
    #1;
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_rv", 64'(rv_a), 64'd0);
    check("rst_nx", 64'(nx_a), 64'd0);
    check("rst_ns", 64'(ns_a), 64'd0);
    check("rst_flags", 64'({ovf_a, nos_a}), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // No fx at all: abort after the timeout with zero counts.
    en_a = 1'b1;
    @(negedge clk);
    gate_tick = 1'b1;
    e.nx = 0; e.ns = 0; e.ovf = 1'b0; e.nos = 1'b1;
    e.t0 = cyc; e.lmin = 53; e.lmax = 56;  // 2-3 cycles of sync plus 51-53
    q_a.push_back(e);
    repeat (4) @(negedge clk);
    gate_tick = 1'b0;
    en_a = 1'b0;
    drain();

    run_meas(10, 25, 200, 1'b0);   // nx=20, ns=200
    run_meas(6, 23, 123, 1'b0);    // closing tick lands on an fx edge
    run_meas(4, 21, 400, 1'b1);    // 8-bit ns saturates

    // Async reset in the middle of COUNT.
    en_a = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      fx = (i >= 5) && (((i - 5) % 10) < 5);
      gate_tick = (i >= 2 && i < 6);
    end
    check("pre_reset_busy", 64'(busy_a), 64'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy_a), 64'd0);
    check("abort_rv", 64'(rv_a), 64'd0);
    check("abort_nx", 64'(nx_a), 64'd0);
    check("abort_ns", 64'(ns_a), 64'd0);
    check("abort_flags", 64'({ovf_a, nos_a}), 64'd0);
    fx = 1'b0;
    gate_tick = 1'b0;
    en_a = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    run_meas(7, 23, 100, 1'b0);    // nx=14, ns=98

    // Ticks with enable low never start a measurement.
    busy_seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      fx = ((i % 5) < 2);
      gate_tick = (i >= 10 && i < 14) || (i >= 40 && i < 44);
    end
    fx = 1'b0;
    gate_tick = 1'b0;
    repeat (10) @(negedge clk);
    check("en_low_busy", 64'(busy_seen), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
